// File: rtl/bus_fabric.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bus_fabric
// Table-driven interconnect between the picorv32 native memory port and up to
// 16 peripheral slaves. Each slave owns a set of 4 KiB pages (m_addr[15:12])
// and completes either after a fixed latency generated here (1-3 cycles) or
// on its own s_ready (handshake mode, guarded by a hang timeout). Unmapped and
// timed-out accesses complete with ERR_DATA and are reported on err_*.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   m_valid/m_ready     picorv32 mem_valid / mem_ready
//   m_addr, m_wstrb     picorv32 address (only [15:12] decoded) and strobes
//   m_rdata             read data to the core (0 when m_ready is low)
//   s_cs                one-hot slave select (combinational)
//   s_wstrb             per-slave write strobes, 4 bits per slave
//   s_ready, s_rdata    per-slave completion and read data
//   err_irq             one-cycle pulse on an error completion
//   err_addr, err_cause address and cause (01 unmapped, 10 timeout) of last error
// -----------------------------------------------------------------------------
module bus_fabric #(
  parameter int unsigned                  NUM_SLAVES    = 8,
  parameter logic [16*NUM_SLAVES-1:0]     SLAVE_PAGES   = {NUM_SLAVES{16'h0000}},
  parameter logic [2*NUM_SLAVES-1:0]      SLAVE_LATENCY = {NUM_SLAVES{2'd1}},
  parameter int unsigned                  TIMEOUT       = 255,
  parameter logic [31:0]                  ERR_DATA      = 32'hDEADBEEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      m_valid,
  output logic                      m_ready,
  input  logic [31:0]               m_addr,
  input  logic [3:0]                m_wstrb,
  output logic [31:0]               m_rdata,
  output logic [NUM_SLAVES-1:0]     s_cs,
  output logic [4*NUM_SLAVES-1:0]   s_wstrb,
  input  logic [NUM_SLAVES-1:0]     s_ready,
  input  logic [32*NUM_SLAVES-1:0]  s_rdata,
  output logic                      err_irq,
  output logic [31:0]               err_addr,
  output logic [1:0]                err_cause
);

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [31:0]             err_addr_q;
  logic [1:0]              err_cause_q;

  logic [3:0]              page_s;
  logic [15:0]             pages_s;
  logic [NUM_SLAVES-1:0]   match_s;
  logic [NUM_SLAVES-1:0]   onehot_s;
  logic                    hit_s;
  logic                    hs_s;
  logic [1:0]              lat_sel_s;
  logic                    rdy_sel_s;
  logic [31:0]             rdata_sel_s;
  logic                    done_s;
  logic                    err_s;
  logic [1:0]              cause_s;

  assign page_s = m_addr[15:12];

  // Page-table lookup: which slaves claim the current page.
  always_comb begin
    match_s = {NUM_SLAVES{1'b0}};
    pages_s = 16'h0000;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      pages_s    = SLAVE_PAGES[16*i +: 16];
      match_s[i] = m_valid & pages_s[page_s];
    end
  end

  // Isolate the lowest set bit so the lowest-indexed owner wins.
  assign onehot_s = match_s & (~match_s + NUM_SLAVES'(1'b1));
  assign hit_s    = |onehot_s;

  // AND-OR muxes driven by the one-hot select; also fans out write strobes.
  always_comb begin
    rdata_sel_s = 32'h0000_0000;
    lat_sel_s   = 2'd0;
    rdy_sel_s   = 1'b0;
    s_wstrb     = {(4*NUM_SLAVES){1'b0}};
    for (int i = 0; i < NUM_SLAVES; i++) begin
      rdata_sel_s        = rdata_sel_s | ({32{onehot_s[i]}} & s_rdata[32*i +: 32]);
      lat_sel_s          = lat_sel_s | ({2{onehot_s[i]}} & SLAVE_LATENCY[2*i +: 2]);
      rdy_sel_s          = rdy_sel_s | (onehot_s[i] & s_ready[i]);
      s_wstrb[4*i +: 4]  = {4{onehot_s[i]}} & m_wstrb;
    end
  end

  assign hs_s = hit_s & (lat_sel_s == 2'd0);

  // Completion detection for the current cycle.
  always_comb begin
    done_s  = 1'b0;
    err_s   = 1'b0;
    cause_s = 2'b00;
    case (state_q)
      ST_IDLE: begin
        // Only a handshake slave that is already ready can finish with no wait.
        if (hs_s && rdy_sel_s) begin
          done_s = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      ST_BUSY: begin
        if (!m_valid) begin
          done_s = 1'b0;
        end else if (!hit_s) begin
          done_s  = (cnt_q == 16'd1);
          err_s   = (cnt_q == 16'd1);
          cause_s = 2'b01;
        end else if (hs_s) begin
          if (rdy_sel_s) begin
            done_s = 1'b1;
          end else if (cnt_q == TIMEOUT_C) begin
            done_s  = 1'b1;
            err_s   = 1'b1;
            cause_s = 2'b10;
          end else begin
            done_s = 1'b0;
          end
        end else begin
          done_s = (cnt_q == {14'd0, lat_sel_s});
        end
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // Next-state and wait-counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (m_valid && !done_s) begin
          state_d = ST_BUSY;
          cnt_d   = 16'd1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end
      end
      ST_BUSY: begin
        // A dropped m_valid also returns to IDLE so the fabric cannot lock up.
        if (!m_valid || done_s) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end else begin
          state_d = ST_BUSY;
          cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // State, counter and error-report registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      err_addr_q  <= 32'h0000_0000;
      err_cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (err_s) begin
        err_addr_q  <= m_addr;
        err_cause_q <= cause_s;
      end else begin
        err_addr_q  <= err_addr_q;
        err_cause_q <= err_cause_q;
      end
    end
  end

  assign s_cs      = onehot_s;
  assign m_ready   = done_s;
  assign err_irq   = err_s;
  assign m_rdata   = done_s ? (err_s ? ERR_DATA : rdata_sel_s) : 32'h0000_0000;
  assign err_addr  = err_addr_q;
  assign err_cause = err_cause_q;

endmodule

// File: doc/bus_fabric.md
# bus_fabric

Parametrised memory-bus interconnect between the picorv32 native memory port and up to 16 peripheral slaves. It replaces hand-written chip-select, ready and read-mux logic with a table-driven decoder. Each slave gets a configurable 4 KiB page map and a completion mode: fixed latency, or its own ready. The fabric adds a hang timeout and reports unmapped and timed-out accesses.

## Interface
Parameters:
- `NUM_SLAVES`, 8: number of slave ports, 1–16.
- `SLAVE_PAGES`, {NUM_SLAVES{16'h0000}}: packed, 16 bits per slave. For slave i, bit p set means slave i owns page p (m_addr[15:12]==p).
- `SLAVE_LATENCY`, {NUM_SLAVES{2'd1}}: packed, 2 bits per slave.
  - 0 = handshake mode: the slave drives s_ready.
  - 1–3 = fixed latency: the fabric generates ready and ignores s_ready.
- `TIMEOUT`, 255: maximum wait, in cycles, for a handshake slave. Range 1–65535.
- `ERR_DATA`, 32'hDEADBEEF: read data returned on an error completion.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m_valid`  in  1  picorv32 mem_valid.
- `m_ready`  out  1  picorv32 mem_ready.
- `m_addr`  in  32  picorv32 mem_addr. Only [15:12] is decoded.
- `m_wstrb`  in  4  picorv32 mem_wstrb. All zero means a read.
- `m_rdata`  out  32  picorv32 mem_rdata.
- `s_cs`  out  NUM_SLAVES  one-hot slave select.
- `s_wstrb`  out  4*NUM_SLAVES  per-slave write strobes. Equal to m_wstrb for the selected slave, 0 for all others.
- `s_ready`  in  NUM_SLAVES  slave completion. Sampled only in handshake mode.
- `s_rdata`  in  32*NUM_SLAVES  per-slave read data.
- `err_irq`  out  1  one-cycle pulse on each error completion.
- `err_addr`  out  32  m_addr of the most recent error.
- `err_cause`  out  2  cause of the most recent error: 01 = unmapped, 10 = timeout.

## Operation
Decode:
- Slave i matches when m_valid is high and SLAVE_PAGES[16*i+p] is set for p = m_addr[15:12].
- If several slaves match, the lowest index wins.
- s_cs is combinational from m_valid and m_addr. It is held for every cycle of the transaction, including the ready cycle.
- Slave addr/wdata are not routed through the fabric; slaves take m_addr/m_wdata directly.

State machine (IDLE, BUSY):
- **IDLE:**
  - m_valid low: stay in IDLE.
  - m_valid high, selected slave in handshake mode, s_ready high: complete in the same cycle (zero-wait) and stay in IDLE.
  - m_valid high, any other case: go to BUSY with cnt = 1.
- **BUSY:** cnt increments each cycle. The transaction completes when any one of these holds:
  - Fixed-latency slave and cnt == latency.
  - Handshake slave and s_ready high.
  - Unmapped address and cnt == 1.
  - Handshake slave and cnt == TIMEOUT, with s_ready still low.
- On completion: m_ready is high for exactly that one cycle, the next state is IDLE, and cnt clears.

Read data:
- Normal completion: m_rdata = s_rdata of the selected slave.
- Error completion (unmapped or timeout): m_rdata = ERR_DATA.
- When m_ready is low: m_rdata = 0.

Errors:
- err_irq pulses for one cycle, coincident with the error ready.
- err_addr and err_cause update on the clock edge closing the error cycle and hold until the next error.
- On timeout, s_cs stays asserted through the ready cycle. A late s_ready after that is ignored.

Write side effects:
- s_wstrb is asserted on every cycle of a write.
- Any slave whose writes have side effects (FIFOs, UARTs) must use handshake mode and act only in its s_ready cycle.

## Timing
- Reset (async assert, sync release):
  - State IDLE, cnt 0.
  - m_ready 0, err_irq 0, err_addr 0, err_cause 00.
  - m_rdata and s_cs follow inputs combinationally (0 while m_valid is low).
- Fixed latency L: m_ready is high L cycles after the first m_valid cycle. L = 1 matches a registered BRAM.
- Handshake: minimum 0 wait cycles. A timeout completes TIMEOUT cycles after the first m_valid cycle.
- Unmapped access: always 1 cycle.
- Back-to-back transactions: picorv32 may reassert m_valid in the cycle after m_ready. That cycle is a new transaction from IDLE; no dead cycle is required.
- Reset asserted mid-BUSY: the transaction is aborted immediately, m_ready goes to 0, and the fabric returns to IDLE.
- m_valid dropping while in BUSY is illegal for picorv32. It need not be handled, but the fabric must not lock up: it returns to IDLE when m_valid is low in BUSY.
- cnt is 16 bits wide, saturating; it never wraps.

## Test plan
- **Fixed latency, read:** slave 0 owns pages 0–3 with latency 1. Read 0x0000_1004 with s_rdata0 = 0x12345678 → m_ready in cycle 1 only; m_rdata = 0x12345678; s_cs = 0x01 in cycles 0–1.
- **Zero-wait handshake, write:** slave 4 is handshake mode and owns page A. Write 0xA000 with wstrb 0001 and s_ready4 already high → m_ready in cycle 0; s_wstrb[19:16] = 0001; all other s_wstrb lanes 0.
- **Unmapped read:** read 0xF000 with no slave mapping page F → m_ready in cycle 1; m_rdata = 0xDEADBEEF; err_irq pulses once; err_addr = 0x0000F000; err_cause = 01.
- **Timeout:** TIMEOUT = 8 and s_ready never rises → m_ready in cycle 8; rdata = ERR_DATA; err_cause = 10. A following read to a latency-2 slave completes normally in cycle 2.
- **Overlap and back-to-back:** slaves 1 and 2 both own page 8. Two consecutive reads with no gap → slave 1 is selected both times; two clean ready pulses.
- **Reset mid-transaction:** pull rst_n low in cycle 1 of a latency-3 access → m_ready never asserts; state IDLE. After release, a new access completes in cycle 3.
